// File: rtl/icap_s6_cmd_seq.sv
// icap_s6_cmd_seq: turns single configuration-register read/write requests
// into the Spartan-6 ICAP 16-bit word stream (dummy, sync, NOOP, type-1
// header, data, desync). It drives CE/WRITE/I of the ICAP and captures O
// on reads.
//
// Optional build macro ICAP_BITSWAP_EN: when defined, every word on ICAP_I
// and every word captured from ICAP_O is bit-reversed within each byte.
//
// Handshake: a request transfers on a rising CLK edge where
// REQ_VALID && REQ_READY. Request fields are sampled only on that edge.
// RESP_VALID is a single-cycle pulse with no back-pressure.
// RESP_ERR and RESP_DATA are meaningful while RESP_VALID is high.
// RESP_DATA then holds until the next pulse.
//
// All outputs are registered from the current state. A state's word
// therefore appears on ICAP_I one edge after the state is entered.
module icap_s6_cmd_seq #(
  parameter int RD_TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WRITE,
  input  logic [5:0]  REQ_ADDR,
  input  logic [15:0] REQ_WDATA,
  output logic        RESP_VALID,
  output logic        RESP_ERR,
  output logic [15:0] RESP_DATA,
  output logic        ICAP_CE,
  output logic        ICAP_WRITE,
  output logic [15:0] ICAP_I,
  input  logic [15:0] ICAP_O,
  input  logic        ICAP_BUSY,
  output logic [3:0]  DBG_STATE
);

  // The timeout counter counts 0..RD_TIMEOUT-1.
  localparam int TW = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT);
  localparam logic [TW-1:0] CNT_LAST = TW'(RD_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRE,
    S_WDAT,
    S_RNOP,
    S_RCEOFF,
    S_RTURN,
    S_RWAIT,
    S_RBACK,
    S_DESYNC,
    S_DONE
  } state_t;

  // Map between logical word order and the ICAP pin order.
  function automatic logic [15:0] io_map(input logic [15:0] w);
`ifdef ICAP_BITSWAP_EN
    logic [15:0] r;
    for (int b = 0; b < 8; b++) begin
      r[b]     = w[7-b];
      r[8+b]   = w[15-b];
    end
    return r;
`else
    return w;
`endif
  endfunction

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [5:0]    addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_err_q, resp_err_d;
  logic [15:0]   resp_data_q, resp_data_d;
  logic          ce_q, ce_d;
  logic          iwr_q, iwr_d;
  logic [15:0]   i_q, i_d;

  logic          accept;
  logic [15:0]   word;
  logic [15:0]   hdr;

  assign accept = (state_q == S_IDLE) && req_ready_q && REQ_VALID;
  assign hdr    = (wr_q ? 16'h3001 : 16'h2801) | {5'b0, addr_q, 5'b0};

  // Next-state, word selection and registered-output values.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_data_d  = resp_data_q;
    ce_d         = 1'b1;
    iwr_d        = 1'b0;
    word         = 16'hFFFF;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          wr_d    = REQ_WRITE;
          addr_d  = REQ_ADDR;
          wdata_d = REQ_WDATA;
          err_d   = 1'b0;
          rdata_d = 16'h0000;
          idx_d   = 3'd0;
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        ce_d = 1'b0;
        case (idx_q)
          3'd0:    word = 16'hFFFF;
          3'd1:    word = 16'hAA99;
          3'd2:    word = 16'h5566;
          3'd3:    word = 16'h2000;
          default: word = hdr;
        endcase
        if (idx_q == 3'd4) begin
          idx_d   = 3'd0;
          state_d = wr_q ? S_WDAT : S_RNOP;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_WDAT: begin
        ce_d = 1'b0;
        word = (idx_q == 3'd0) ? wdata_q : 16'h2000;
        if (idx_q == 3'd2) begin
          idx_d   = 3'd0;
          state_d = S_DESYNC;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_RNOP: begin
        ce_d = 1'b0;
        word = 16'h2000;
        if (idx_q == 3'd1) begin
          idx_d   = 3'd0;
          state_d = S_RCEOFF;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_RCEOFF: begin
        state_d = S_RTURN;
      end
      S_RTURN: begin
        iwr_d   = 1'b1;
        cnt_d   = '0;
        state_d = S_RWAIT;
      end
      S_RWAIT: begin
        ce_d  = 1'b0;
        iwr_d = 1'b1;
        if (!ICAP_BUSY) begin
          rdata_d = io_map(ICAP_O);
          idx_d   = 3'd0;
          state_d = S_RBACK;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          rdata_d = 16'h0000;
          idx_d   = 3'd0;
          state_d = S_RBACK;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_RBACK: begin
        // WRITE drops back to 0 only after CE has been high for a cycle.
        iwr_d = (idx_q == 3'd0);
        if (idx_q == 3'd1) begin
          idx_d   = 3'd0;
          state_d = S_DESYNC;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_DESYNC: begin
        ce_d = 1'b0;
        case (idx_q)
          3'd0:    word = 16'h30A1;
          3'd1:    word = 16'h000D;
          default: word = 16'h2000;
        endcase
        if (idx_q == 3'd3) begin
          idx_d   = 3'd0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_DONE: begin
        resp_valid_d = 1'b1;
        resp_err_d   = err_q;
        resp_data_d  = (wr_q || err_q) ? 16'h0000 : rdata_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    i_d         = io_map(word);
    req_ready_d = (state_q == S_IDLE) && !ICAP_BUSY && !accept;
  end

  // State and all registered outputs; reset forces the ICAP idle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      idx_q        <= 3'd0;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      addr_q       <= 6'd0;
      wdata_q      <= 16'h0000;
      err_q        <= 1'b0;
      rdata_q      <= 16'h0000;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= 16'h0000;
      ce_q         <= 1'b1;
      iwr_q        <= 1'b0;
      i_q          <= 16'hFFFF;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
      ce_q         <= ce_d;
      iwr_q        <= iwr_d;
      i_q          <= i_d;
    end
  end

  assign REQ_READY  = req_ready_q;
  assign RESP_VALID = resp_valid_q;
  assign RESP_ERR   = resp_err_q;
  assign RESP_DATA  = resp_data_q;
  assign ICAP_CE    = ce_q;
  assign ICAP_WRITE = iwr_q;
  assign ICAP_I     = i_q;
  assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_icap_s6_cmd_seq.sv
// tb_icap_s6_cmd_seq: directed, table-driven bench for icap_s6_cmd_seq.
// Each table row holds the ICAP_BUSY/ICAP_O values for one cycle and the
// outputs expected after the corresponding edge of a transaction.
module tb_icap_s6_cmd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [5:0]  req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [15:0] resp_data;
  logic        icap_ce;
  logic        icap_write;
  logic [15:0] icap_i;
  logic [15:0] icap_o;
  logic        icap_busy;
  logic [3:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  icap_s6_cmd_seq #(.RD_TIMEOUT(8)) dut (
    .CLK        (clk),
    .RST        (rst),
    .REQ_VALID  (req_valid),
    .REQ_READY  (req_ready),
    .REQ_WRITE  (req_write),
    .REQ_ADDR   (req_addr),
    .REQ_WDATA  (req_wdata),
    .RESP_VALID (resp_valid),
    .RESP_ERR   (resp_err),
    .RESP_DATA  (resp_data),
    .ICAP_CE    (icap_ce),
    .ICAP_WRITE (icap_write),
    .ICAP_I     (icap_i),
    .ICAP_O     (icap_o),
    .ICAP_BUSY  (icap_busy),
    .DBG_STATE  (dbg_state)
  );

  typedef struct {
    logic        busy;
    logic [15:0] o;
    logic        ce;
    logic        wr;
    logic [15:0] i;
    logic        rv;
    logic        err;
    logic        rdy;
    logic        chk;
    logic [15:0] d;
  } vec_t;

  vec_t tbl[$];

  // Logical word to pin order, matching the build option.
  function automatic logic [15:0] sw(input logic [15:0] w);
`ifdef ICAP_BITSWAP_EN
    logic [15:0] r;
    for (int b = 0; b < 8; b++) begin
      r[b]   = w[7-b];
      r[8+b] = w[15-b];
    end
    return r;
`else
    return w;
`endif
  endfunction

  function automatic vec_t mk(input logic busy, input logic [15:0] o,
                              input logic ce, input logic wr, input logic [15:0] i,
                              input logic rv, input logic err, input logic rdy,
                              input logic chk, input logic [15:0] d);
    vec_t v;
    v.busy = busy;
    v.o    = o;
    v.ce   = ce;
    v.wr   = wr;
    v.i    = sw(i);
    v.rv   = rv;
    v.err  = err;
    v.rdy  = rdy;
    v.chk  = chk;
    v.d    = d;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Write transaction: 12 words, DONE, then one idle cycle.
  task automatic build_write(input logic [5:0] a, input logic [15:0] wd);
    logic [15:0] w[12];
    logic [15:0] hdr;
    hdr = 16'h3001 | {5'b0, a, 5'b0};
    w = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h2000, hdr, wd,
          16'h2000, 16'h2000, 16'h30A1, 16'h000D, 16'h2000, 16'h2000};
    tbl.delete();
    for (int k = 0; k < 12; k++)
      tbl.push_back(mk(1'b0, 16'hBEEF, 1'b0, 1'b0, w[k], 1'b0, 1'b0, 1'b0, 1'b0, 16'h0));
    tbl.push_back(mk(1'b0, 16'hBEEF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0));
    tbl.push_back(mk(1'b0, 16'hBEEF, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0));
  endtask

  // Read transaction with b RWAIT cycles; timeout keeps BUSY high throughout.
  task automatic build_read(input logic [5:0] a, input int b, input logic [15:0] oval,
                            input logic timeout);
    logic [15:0] pre[5];
    logic [15:0] ds[4];
    logic [15:0] dexp;
    logic        bz;
    logic [15:0] ov;
    pre  = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h2000, 16'h2801 | {5'b0, a, 5'b0}};
    ds   = '{16'h30A1, 16'h000D, 16'h2000, 16'h2000};
    dexp = timeout ? 16'h0000 : oval;
    tbl.delete();
    for (int k = 1; k <= 17 + b; k++) begin
      bz = timeout ? 1'b1 : (k < 8 + b);
      ov = (!timeout && k == 8 + b) ? sw(oval) : 16'hBEEF;
      if (k <= 5)
        tbl.push_back(mk(bz, ov, 1'b0, 1'b0, pre[k-1], 1'b0, 1'b0, 1'b0, 1'b0, 16'h0));
      else if (k <= 7)
        tbl.push_back(mk(bz, ov, 1'b0, 1'b0, 16'h2000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0));
      else if (k == 8)
        tbl.push_back(mk(bz, ov, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0));
      else if (k == 9)
        tbl.push_back(mk(bz, ov, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0));
      else if (k <= 9 + b)
        tbl.push_back(mk(bz, ov, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0));
      else if (k == 10 + b)
        tbl.push_back(mk(bz, ov, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0));
      else if (k == 11 + b)
        tbl.push_back(mk(bz, ov, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0));
      else if (k <= 15 + b)
        tbl.push_back(mk(bz, ov, 1'b0, 1'b0, ds[k-12-b], 1'b0, 1'b0, 1'b0, 1'b0, 16'h0));
      else if (k == 16 + b)
        tbl.push_back(mk(bz, ov, 1'b1, 1'b0, 16'hFFFF, 1'b1, timeout, 1'b0, 1'b1, dexp));
      else
        tbl.push_back(mk(bz, ov, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, !timeout, 1'b1, dexp));
    end
  endtask

  // Driver: call at a negedge; present a request and wait for acceptance.
  task automatic do_req(input logic wr, input logic [5:0] a, input logic [15:0] wd,
                        input int limit, output int waited);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    waited    = 0;
    while (!req_ready && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL req_accept: REQ_READY still %b after %0d cycles", req_ready, waited);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_wdata = 16'h5A5A;
      req_addr  = 6'h3F;
    end
  endtask

  // Apply the table one cycle per row; also check WRITE is stable while CE is low.
  task automatic run_tbl(input string nm);
    logic        prev_ce;
    logic        prev_wr;
    logic [20:0] act;
    logic [20:0] exp;
    vec_t        v;
    prev_ce = icap_ce;
    prev_wr = icap_write;
    for (int k = 0; k < tbl.size(); k++) begin
      v = tbl[k];
      @(posedge clk);
      #1;
      icap_busy = v.busy;
      icap_o    = v.o;
      @(negedge clk);
      act = {icap_ce, icap_write, icap_i, resp_valid, resp_err, req_ready};
      exp = {v.ce, v.wr, v.i, v.rv, v.err, v.rdy};
      total++;
      if (act !== exp || (v.chk && resp_data !== v.d)) begin
        bad++;
        $display("FAIL %s[%0d]: ce/wr/i/rv/err/rdy=%b/%b/%h/%b/%b/%b data=%h, expected %b/%b/%h/%b/%b/%b data=%h",
                 nm, k + 1, icap_ce, icap_write, icap_i, resp_valid, resp_err, req_ready, resp_data,
                 v.ce, v.wr, v.i, v.rv, v.err, v.rdy, v.chk ? v.d : resp_data);
      end
      if (!prev_ce && !icap_ce) begin
        total++;
        if (icap_write !== prev_wr) begin
          bad++;
          $display("FAIL %s_wr_stable[%0d]: WRITE %b while CE low, required %b", nm, k + 1,
                   icap_write, prev_wr);
        end
      end
      prev_ce = icap_ce;
      prev_wr = icap_write;
    end
  endtask

  initial begin
    int w;
    int gate_bad;
    int rv_seen;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 6'h00;
    req_wdata = 16'h0000;
    icap_o    = 16'hBEEF;
    icap_busy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset", {44'h0, icap_ce, icap_write, icap_i, req_ready, resp_valid},
        {44'h0, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0});
    chk("reset_resp", {43'h0, resp_err, resp_data, dbg_state}, {43'h0, 1'b0, 16'h0000, 4'h0});

    // Init gating: BUSY high with a request pending.
    rst       = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 6'h05;
    req_wdata = 16'h000E;
    gate_bad  = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (req_ready !== 1'b0 || icap_ce !== 1'b1) gate_bad++;
    end
    chk("init_gate", 64'(gate_bad), 64'd0);
    icap_busy = 1'b0;
    do_req(1'b1, 6'h05, 16'h000E, 10, w);
    chk("init_accept_delay", 64'(w), 64'd1);
    build_write(6'h05, 16'h000E);
    run_tbl("write");

    // Back-to-back read: IDCODE with BUSY low on the third RWAIT cycle.
    do_req(1'b0, 6'h0E, 16'h0000, 10, w);
    chk("b2b_accept_delay", 64'(w), 64'd0);
    build_read(6'h0E, 3, 16'h0093, 1'b0);
    run_tbl("read");

    // Timeout read: BUSY stuck high.
    do_req(1'b0, 6'h0C, 16'h0000, 10, w);
    build_read(6'h0C, 8, 16'h0000, 1'b1);
    run_tbl("timeout");
    icap_busy = 1'b0;

    // Reset in the middle of a write.
    do_req(1'b1, 6'h05, 16'h1111, 10, w);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst", {45'h0, icap_ce, icap_write, icap_i, resp_valid},
        {45'h0, 1'b1, 1'b0, 16'hFFFF, 1'b0});
    @(posedge clk);
    #1;
    rst     = 1'b0;
    rv_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) rv_seen++;
    end
    chk("midrst_no_resp", 64'(rv_seen), 64'd0);
    do_req(1'b1, 6'h10, 16'h1234, 10, w);
    build_write(6'h10, 16'h1234);
    run_tbl("write2");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
